// File: rtl/multicycle_control.sv
// Multicycle ARM-subset control unit: main FSM, datapath-control decode,
// condition evaluation and the NZCV flags register.
module multicycle_control (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         AdrSrc,
  output logic         MemWrite,
  output logic         IRWrite,
  output logic         RegWrite,
  output logic         ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl,
  output logic [3:0]   State
);

  localparam logic [3:0] FETCH  = 4'd0;
  localparam logic [3:0] DECODE = 4'd1;
  localparam logic [3:0] MEMADR = 4'd2;
  localparam logic [3:0] MEMRD  = 4'd3;
  localparam logic [3:0] MEMWB  = 4'd4;
  localparam logic [3:0] MEMWR  = 4'd5;
  localparam logic [3:0] EXECR  = 4'd6;
  localparam logic [3:0] EXECI  = 4'd7;
  localparam logic [3:0] ALUWB  = 4'd8;
  localparam logic [3:0] BRANCH = 4'd9;

  logic [3:0] state_r, next_state_s, cur_s;
  logic [3:0] flags_r;
  logic       condexr_r, condex_s;
  logic [3:0] cond_s, cmd_s, rd_s;
  logic [1:0] op_s;
  logic [5:0] funct_s;
  logic [1:0] dp_alu_s;
  logic       dp_valid_s, dp_cmp_s, dp_arith_s, flag_upd_s;

  assign cond_s  = Instr[31:28];
  assign op_s    = Instr[27:26];
  assign funct_s = Instr[25:20];
  assign rd_s    = Instr[15:12];
  assign cmd_s   = funct_s[4:1];

  // ARM condition-code table over {N,Z,C,V}; 1111 never executes
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: cond_eval = z;
      4'b0001: cond_eval = ~z;
      4'b0010: cond_eval = c;
      4'b0011: cond_eval = ~c;
      4'b0100: cond_eval = n;
      4'b0101: cond_eval = ~n;
      4'b0110: cond_eval = v;
      4'b0111: cond_eval = ~v;
      4'b1000: cond_eval = c & ~z;
      4'b1001: cond_eval = ~c | z;
      4'b1010: cond_eval = (n == v);
      4'b1011: cond_eval = (n != v);
      4'b1100: cond_eval = ~z & (n == v);
      4'b1101: cond_eval = z | (n != v);
      4'b1110: cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  assign condex_s = cond_eval(cond_s, flags_r);

  // Data-processing command decode
  always_comb begin
    dp_alu_s   = 2'b00;
    dp_valid_s = 1'b1;
    dp_cmp_s   = 1'b0;
    dp_arith_s = 1'b0;
    case (cmd_s)
      4'b0100: dp_arith_s = 1'b1;
      4'b0010: begin dp_alu_s = 2'b01; dp_arith_s = 1'b1; end
      4'b1010: begin dp_alu_s = 2'b01; dp_arith_s = 1'b1; dp_cmp_s = 1'b1; end
      4'b0000: dp_alu_s = 2'b10;
      4'b1100: dp_alu_s = 2'b11;
      default: dp_valid_s = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    next_state_s = FETCH;
    case (state_r)
      FETCH:  next_state_s = DECODE;
      DECODE: begin
        case (op_s)
          2'b00:   next_state_s = funct_s[5] ? EXECI : EXECR;
          2'b01:   next_state_s = MEMADR;
          2'b10:   next_state_s = BRANCH;
          default: next_state_s = FETCH;
        endcase
      end
      MEMADR: next_state_s = funct_s[0] ? MEMRD : MEMWR;
      MEMRD:  next_state_s = MEMWB;
      EXECR:  next_state_s = ALUWB;
      EXECI:  next_state_s = ALUWB;
      default: next_state_s = FETCH;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_r <= FETCH;
    else       state_r <= next_state_s;
  end

  // Condition outcome captured once per instruction at the end of DECODE
  always_ff @(posedge clk) begin
    if (reset)                  condexr_r <= 1'b0;
    else if (state_r == DECODE) condexr_r <= condex_s;
    else                        condexr_r <= condexr_r;
  end

  assign flag_upd_s = ((state_r == EXECR) || (state_r == EXECI)) && funct_s[0] && condexr_r;

  // Flags register; logical ops keep C and V
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_r <= 4'b0000;
    end else if (flag_upd_s) begin
      flags_r[3:2] <= ALUFlags[3:2];
      flags_r[1:0] <= dp_arith_s ? ALUFlags[1:0] : flags_r[1:0];
    end else begin
      flags_r <= flags_r;
    end
  end

  // Reset forces the FETCH decode so no stale write strobe escapes
  assign cur_s  = reset ? FETCH : state_r;
  assign State  = cur_s;
  assign ImmSrc = op_s;
  assign RegSrc = {(op_s == 2'b01), (op_s == 2'b10)};

  // Per-state output decode
  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = 2'b00;
    case (cur_s)
      FETCH: begin
        IRWrite = 1'b1; ALUSrcA = 1'b1; ALUSrcB = 2'b10;
        ResultSrc = 2'b10; PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcA = 1'b1; ALUSrcB = 2'b10; ResultSrc = 2'b10;
      end
      MEMADR: begin
        ALUSrcB = 2'b01;
        ALUControl = funct_s[3] ? 2'b00 : 2'b01;
      end
      MEMRD: AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc = 1'b1; MemWrite = condexr_r;
      end
      MEMWB: begin
        ResultSrc = 2'b01; RegWrite = condexr_r;
        PCWrite = condexr_r && (rd_s == 4'b1111);
      end
      EXECR: ALUControl = dp_alu_s;
      EXECI: begin
        ALUSrcB = 2'b01; ALUControl = dp_alu_s;
      end
      ALUWB: begin
        ALUControl = dp_alu_s;
        RegWrite = condexr_r & dp_valid_s & ~dp_cmp_s;
        PCWrite = condexr_r && (rd_s == 4'b1111);
      end
      BRANCH: begin
        ALUSrcB = 2'b01; ResultSrc = 2'b10; PCWrite = condexr_r;
      end
      default: PCWrite = 1'b0;
    endcase
  end

endmodule
